// File: rtl/fp16_mul_seq_if.sv
// fp16_mul_seq_if: operand/result handshake bundle for the FP16 sequential multiplier.
interface fp16_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, flags);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp16_mul_seq.sv
// fp16_mul_seq: multi-cycle FP16 multiplier, serial 11-cycle shift-add mantissa product.
// Define FP16_MUL_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp16_mul_seq (
  input logic           clk,
  input logic           rst_n,
  fp16_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ALIGN, MULT, NORM, ROUND, DONE} state_t;
  state_t            r_state;
  logic [15:0]       r_a, r_b;
  logic              r_sign, r_g, r_s;
  logic signed [6:0] r_exp;
  logic [21:0]       r_p, r_mcand;
  logic [10:0]       r_mplier;
  logic [3:0]        r_cnt;
  logic [9:0]        r_frac;
  logic [4:0]        w_ea, w_eb;
  logic              w_invalid, w_inf, w_zero, w_sign, w_inc, w_ovf, w_unf;
  logic signed [6:0] w_exp_sum, w_exp_r;
  logic [10:0]       w_frac_r;
  assign w_ea      = r_a[14:10];
  assign w_eb      = r_b[14:10];
  assign w_sign    = r_a[15] ^ r_b[15];
  // subnormals have exp 0 and therefore fall into the zero class
  assign w_inf     = (&w_ea & ~|r_a[9:0]) | (&w_eb & ~|r_b[9:0]);
  assign w_zero    = ~|w_ea | ~|w_eb;
  assign w_invalid = (&w_ea & |r_a[9:0]) | (&w_eb & |r_b[9:0]) | (w_inf & w_zero);
  assign w_exp_sum = $signed({2'b0, w_ea}) + $signed({2'b0, w_eb}) - 7'sd15;
`ifdef FP16_MUL_RNE_EN
  assign w_inc = r_g & (r_s | r_frac[0]);
`else
  assign w_inc = 1'b0;
`endif
  assign w_frac_r = {1'b0, r_frac} + {10'b0, w_inc};
  assign w_exp_r  = r_exp + $signed({6'b0, w_frac_r[10]});
  assign w_ovf    = w_exp_r > 7'sd30;
  assign w_unf    = w_exp_r < 7'sd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_sign        <= 1'b0;
      r_g           <= 1'b0;
      r_s           <= 1'b0;
      r_exp         <= '0;
      r_p           <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_cnt         <= '0;
      r_frac        <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flags     <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a          <= bus.a;
          r_b          <= bus.b;
          bus.in_ready <= 1'b0;
          r_state      <= ALIGN;
        end
        ALIGN: begin
          r_sign   <= w_sign;
          r_exp    <= w_exp_sum;
          r_p      <= '0;
          r_cnt    <= '0;
          r_mcand  <= {11'b0, |w_ea, r_a[9:0]};
          r_mplier <= {|w_eb, r_b[9:0]};
          if (w_invalid | w_inf | w_zero) begin
            bus.result    <= w_invalid ? 16'h7E00 : {w_sign, w_inf ? 15'h7C00 : 15'h0000};
            bus.flags     <= {w_invalid, 3'b000};
            bus.out_valid <= 1'b1;
            r_state       <= DONE;
          end else
            r_state <= MULT;
        end
        MULT: begin
          r_p     <= r_p + (r_mplier[r_cnt] ? r_mcand : 22'd0);
          r_mcand <= r_mcand << 1;
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) r_state <= NORM;
        end
        NORM: begin
          {r_frac, r_g, r_s} <= r_p[21] ? {r_p[20:11], r_p[10], |r_p[9:0]} : {r_p[19:10], r_p[9], |r_p[8:0]};
          r_exp   <= r_exp + (r_p[21] ? 7'sd1 : 7'sd0);
          r_state <= ROUND;
        end
        ROUND: begin
          bus.result    <= w_ovf ? {r_sign, 15'h7C00} : w_unf ? {r_sign, 15'h0000} : {r_sign, w_exp_r[4:0], w_frac_r[9:0]};
          bus.flags     <= {1'b0, w_ovf, w_unf, w_ovf | w_unf | r_g | r_s};
          bus.out_valid <= 1'b1;
          r_state       <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp16_mul_seq.md
# fp16_mul_seq

Multi-cycle IEEE-754 half-precision (1/5/10) multiplier with its own sequencing FSM. Accepts one operand pair over a valid/ready handshake, classifies the operands, computes the 11×11 mantissa product with a serial shift-add loop, then normalizes, rounds, packs and holds the result until the consumer takes it. Sits behind the FP16 alignment/exponent front end and feeds the result/flag registers of the FP16 multiplier top.

## Interface
- No parameters; fixed FP16 format.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block is IDLE and can accept an operand pair. Reset 1.
- `a` in 16: operand A, FP16.
- `b` in 16: operand B, FP16.
- `out_valid` out 1: result and flags valid. Reset 0.
- `out_ready` in 1: consumer accepts the result.
- `result` out 16: product, FP16. Reset 0x0000.
- `flags` out 4: {invalid, overflow, underflow, inexact}. Reset 0.

## Operation
- FSM states: IDLE → ALIGN → MULT → NORM → ROUND → DONE → IDLE. Reset state is IDLE.
- IDLE: `in_ready`=1. When `in_valid`&`in_ready`, register `a`/`b` and go to ALIGN.
- ALIGN: hidden bit = |exp. Subnormal inputs (exp 0, frac≠0) are flushed to zero. Sign = a[15]^b[15]. exp_sum = ea+eb−15, held as 7-bit signed.
  - NaN input, or Inf×0: result 0x7E00, invalid=1 → DONE.
  - Inf×nonzero: {sign,0x7C00 bits} → DONE.
  - Zero×finite: signed zero → DONE.
  - Otherwise → MULT.
- MULT: exactly 11 cycles. Each cycle tests one multiplier bit (LSB first), conditionally adds the multiplicand into a 22-bit accumulator and shifts. A 4-bit counter selects the bit; on count 10 → NORM.
- NORM: if P[21]=1, take P[20:11] as frac, guard = P[10], sticky = |P[9:0], and exp+1. Otherwise take P[19:10] as frac, guard = P[9], sticky = |P[8:0].
- ROUND: round per Configuration. A mantissa carry-out sets frac to 0 and adds 1 to exp.
  - exp ≥ 31: signed Inf; overflow=1, inexact=1.
  - exp ≤ 0: signed zero; underflow=1, inexact=1.
  - Otherwise pack normally; inexact = guard|sticky.
  - → DONE.
- DONE: `out_valid`=1. `result`/`flags` are stable while `out_valid`&!`out_ready`. On `out_ready` → IDLE.
- `a`/`b` changes outside the accept cycle have no effect.

## Timing
- Accept edge = cycle 0.
- Normal path: `out_valid` rises after the edge ending cycle 14 (1 ALIGN + 11 MULT + 1 NORM + 1 ROUND + 1 DONE entry), i.e. 15 cycles latency.
- Special-case path: `out_valid` after 2 cycles.
- No overlap between operations. `in_ready` returns 1 in the cycle after the `out_ready` handshake. Minimum issue interval: 16 cycles (normal), 3 cycles (special).
- `out_ready` asserted before DONE is ignored.
- `rst_n` low at any time asynchronously forces IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0. Any in-flight operation is discarded.

## Configuration
- `FP16_MUL_RNE_EN` defined: round-to-nearest-even. Increment when guard&(sticky|frac[0]).
- Not defined: truncation (round toward zero). No increment; guard/sticky still drive inexact.

## Test plan
- 0x3C00×0x3C00 → `result`=0x3C00, `flags`=0, `out_valid` exactly 15 cycles after accept; `in_ready`=0 throughout.
- 0x3E00×0x4100 (1.5×2.5) → 0x4380, `flags`=0. Hold `out_ready`=0 for 5 cycles; `result` must stay stable, then handshake and `in_ready`=1 on the next cycle.
- 0x3E00×0x3C01 → with `FP16_MUL_RNE_EN`: 0x3E02, flags=0001. Without it: 0x3E01, flags=0001.
- 0x7BFF×0x4000 → 0x7C00, flags=0101. 0x0400×0x0400 → 0x0000, flags=0011.
- 0x7C00×0x0000 → 0x7E00, flags=1000, latency 2. 0xFC00×0x3C00 → 0xFC00, flags=0.
- Pull `rst_n` low during MULT (cycle 6) → `out_valid`=0 and `in_ready`=1 immediately. After release, 0x4000×0x4000 → 0x4400 at 15-cycle latency.
